// File: rtl/dcache_2way_wt.sv
// Two-way set-associative write-through, no-write-allocate data cache.
// Loads that hit return in the same cycle. Load misses refill through a
// request/acknowledge memory port. Every store is written through to memory;
// a store that hits also updates the cached word. Replacement is LRU per set.
module dcache_2way_wt #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int SET_WIDTH     = 3,
  parameter int TAG_WIDTH     = ADDRESS_WIDTH - SET_WIDTH - 2,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wd,
  output logic [DATA_WIDTH-1:0]    cpu_rd,
  output logic                     cpu_ready,
  input  logic                     flush,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wd,
  input  logic [DATA_WIDTH-1:0]    mem_rd,
  input  logic                     mem_ack,
  output logic [COUNT_WIDTH-1:0]   hit_count,
  output logic [COUNT_WIDTH-1:0]   miss_count
);
  localparam int OFF  = $clog2(DATA_WIDTH / 8);
  localparam int SETS = 1 << SET_WIDTH;
  localparam int WA   = ADDRESS_WIDTH - OFF;   // word-address width

  typedef enum logic [1:0] {IDLE, MISS, WRITE, RESP} state_e;
  state_e state_q, state_d;

  logic [SETS-1:0][1:0]     valid_q, valid_d;
  logic [SETS-1:0]          lru_q, lru_d;     // names the least-recently-used way
  logic [TAG_WIDTH-1:0]     tag_q  [SETS][2];
  logic [DATA_WIDTH-1:0]    data_q [SETS][2];
  logic [WA-1:0]            addr_q, addr_d;   // latched word address
  logic [DATA_WIDTH-1:0]    wd_q, wd_d;
  logic [DATA_WIDTH-1:0]    rd_q, rd_d;       // last load data returned to the CPU
  logic [COUNT_WIDTH-1:0]   hit_q, hit_d, miss_q, miss_d;

  // Array write port, shared by store hits and refills
  logic                     arr_we;
  logic [SET_WIDTH-1:0]     arr_set;
  logic                     arr_way;
  logic [TAG_WIDTH-1:0]     arr_tag;
  logic [DATA_WIDTH-1:0]    arr_data;

  logic [SET_WIDTH-1:0]     cpu_set, lat_set;
  logic [TAG_WIDTH-1:0]     cpu_tag, lat_tag;
  logic [1:0]               hit_way;
  logic                     hit, hit_w, victim;
  logic [DATA_WIDTH-1:0]    hit_data;
  logic                     unused_off;

  assign unused_off = ^cpu_addr[OFF-1:0];

  // Combinational lookup on the live CPU address and victim choice on the latched one
  always_comb begin
    cpu_set  = cpu_addr[OFF +: SET_WIDTH];
    cpu_tag  = cpu_addr[ADDRESS_WIDTH-1 -: TAG_WIDTH];
    hit_way[0] = valid_q[cpu_set][0] && (tag_q[cpu_set][0] == cpu_tag);
    hit_way[1] = valid_q[cpu_set][1] && (tag_q[cpu_set][1] == cpu_tag);
    hit      = |hit_way;
    hit_w    = hit_way[1];
    hit_data = data_q[cpu_set][hit_w];
    lat_set  = addr_q[SET_WIDTH-1:0];
    lat_tag  = addr_q[WA-1 -: TAG_WIDTH];
    // Prefer an empty way (way0 first) before evicting the LRU way
    if (!valid_q[lat_set][0])      victim = 1'b0;
    else if (!valid_q[lat_set][1]) victim = 1'b1;
    else                           victim = lru_q[lat_set];
  end

  // Next-state, array update and CPU/memory handshake outputs
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    lru_d     = lru_q;
    addr_d    = addr_q;
    wd_d      = wd_q;
    rd_d      = rd_q;
    hit_d     = hit_q;
    miss_d    = miss_q;
    arr_we    = 1'b0;
    arr_set   = cpu_set;
    arr_way   = hit_w;
    arr_tag   = cpu_tag;
    arr_data  = cpu_wd;
    cpu_ready = 1'b0;
    cpu_rd    = rd_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush) begin
          valid_d = '0;
          lru_d   = '0;
        end else if (cpu_req) begin
          if (hit) begin
            lru_d[cpu_set] = ~hit_w;
            hit_d = (&hit_q) ? hit_q : hit_q + COUNT_WIDTH'(1);
          end
          if (cpu_we) begin
            arr_we  = hit;   // no-write-allocate: a missing store leaves the array alone
            addr_d  = cpu_addr[ADDRESS_WIDTH-1:OFF];
            wd_d    = cpu_wd;
            state_d = WRITE;
          end else if (hit) begin
            cpu_ready = 1'b1;
            cpu_rd    = hit_data;
            rd_d      = hit_data;
          end else begin
            addr_d  = cpu_addr[ADDRESS_WIDTH-1:OFF];
            miss_d  = (&miss_q) ? miss_q : miss_q + COUNT_WIDTH'(1);
            state_d = MISS;
          end
        end
      end
      MISS: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          arr_we   = 1'b1;
          arr_set  = lat_set;
          arr_way  = victim;
          arr_tag  = lat_tag;
          arr_data = mem_rd;
          valid_d[lat_set][victim] = 1'b1;
          lru_d[lat_set] = ~victim;
          rd_d     = mem_rd;
          state_d  = RESP;
        end
      end
      WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) state_d = RESP;
      end
      RESP: begin
        cpu_ready = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr   = {addr_q, {OFF{1'b0}}};
  assign mem_wd     = wd_q;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

  // Control state, valid/LRU bits, latches and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= '0;
      lru_q   <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      rd_q    <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      lru_q   <= lru_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  // Tag and data storage, not reset (qualified by the valid bits)
  always_ff @(posedge clk) begin
    if (arr_we) begin
      tag_q[arr_set][arr_way]  <= arr_tag;
      data_q[arr_set][arr_way] <= arr_data;
    end
  end
endmodule

// File: tb/tb_dcache_2way_wt.sv
// Randomized bench for dcache_2way_wt. The reference keeps, per set, a
// recency-ordered list of resident word addresses, plus a word memory;
// cached data always equals memory because the cache is write-through.
module tb_dcache_2way_wt;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req, cpu_we, flush, mem_ack;
  logic [31:0]   cpu_addr, cpu_wd, mem_rd;
  logic [31:0]   cpu_rd, mem_addr, mem_wd;
  logic          cpu_ready, mem_req, mem_we;
  logic [CW-1:0] hit_count, miss_count;

  always #5 clk = ~clk;

  dcache_2way_wt #(.COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd), .cpu_ready(cpu_ready), .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_rd(mem_rd), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state
  logic [31:0] mem_m [logic [31:0]];
  logic [31:0] ent [8][2];     // ent[s][0] = most recently used
  int          n_ent [8];

  // Expected outputs for the current cycle
  logic          exp_ready = 0, exp_mreq = 0, exp_mwe = 0, chk_rd = 0;
  logic [31:0]   exp_rd = 0, exp_maddr = 0, exp_mwd = 0;
  logic [CW-1:0] exp_hit = 0, exp_miss = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    int s = int'(a[4:2]);
    for (int i = 0; i < n_ent[s]; i++) if (ent[s][i] == a) return 1'b1;
    return 1'b0;
  endfunction

  // Mark a as most recently used, inserting it (and dropping the LRU one) if absent
  task automatic m_touch(input logic [31:0] a);
    int s = int'(a[4:2]);
    if (n_ent[s] > 0 && ent[s][0] == a) return;
    ent[s][1] = ent[s][0];
    ent[s][0] = a;
    if (n_ent[s] < 2) n_ent[s]++;
  endtask

  task automatic m_clear();
    for (int s = 0; s < 8; s++) n_ent[s] = 0;
  endtask

  // Every-cycle comparison against the expected outputs
  always @(negedge clk) begin
    chk("cpu_ready", {31'b0, cpu_ready}, {31'b0, exp_ready});
    chk("mem_req", {31'b0, mem_req}, {31'b0, exp_mreq});
    if (exp_mreq) begin
      chk("mem_we", {31'b0, mem_we}, {31'b0, exp_mwe});
      chk("mem_addr", mem_addr, exp_maddr);
      if (exp_mwe) chk("mem_wd", mem_wd, exp_mwd);
    end
    if (exp_ready && chk_rd) chk("cpu_rd", cpu_rd, exp_rd);
    chk("hit_count", 32'(hit_count), 32'(exp_hit));
    chk("miss_count", 32'(miss_count), 32'(exp_miss));
  end

  // One CPU access; called and returns at posedge+1
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input int n_ack, input bit fl_mid);
    logic [31:0] a = {addr[31:2], 2'b00};
    bit hit = m_hit(a);
    cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wd = wd;
    exp_mreq = 0; exp_ready = !we && hit; chk_rd = !we; exp_rd = mem_read(a);
    @(posedge clk); #1;
    if (hit) begin m_touch(a); exp_hit = sat_inc(exp_hit); end
    else if (!we) exp_miss = sat_inc(exp_miss);
    if (we) mem_m[a] = wd;
    if (!we && hit) begin cpu_req = 0; exp_ready = 0; return; end
    exp_ready = 0; exp_mreq = 1; exp_mwe = we; exp_maddr = a; exp_mwd = wd;
    for (int i = 1; i <= n_ack; i++) begin
      mem_ack = (i == n_ack);
      mem_rd  = (i == n_ack) ? mem_read(a) : $urandom;
      flush   = fl_mid && (i == 1);
      @(posedge clk); #1;
    end
    mem_ack = 0; flush = 0;
    if (!we) m_touch(a);
    exp_mreq = 0; exp_ready = 1; exp_rd = mem_read(a);
    @(posedge clk); #1;
    cpu_req = 0; exp_ready = 0;
  endtask

  task automatic idle(input int n);
    cpu_req = 0; exp_ready = 0; exp_mreq = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One-cycle flush in IDLE, optionally colliding with a load request
  task automatic flush_cycle(input bit with_req, input logic [31:0] addr);
    flush = 1; cpu_req = with_req; cpu_we = 0; cpu_addr = addr;
    exp_ready = 0; exp_mreq = 0;
    @(posedge clk); #1;
    flush = 0; cpu_req = 0;
    m_clear();
  endtask

  task automatic do_reset();
    rst_n = 0; cpu_req = 0; flush = 0; mem_ack = 0;
    m_clear(); exp_hit = 0; exp_miss = 0; exp_ready = 0; exp_mreq = 0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  initial begin
    logic [31:0] addr;
    logic [26:0] tag;
    rst_n = 1; cpu_req = 0; cpu_we = 0; flush = 0; mem_ack = 0;
    cpu_addr = 0; cpu_wd = 0; mem_rd = 0;
    m_clear();
    #1 rst_n = 0;
    @(posedge clk); #1; @(posedge clk); #1;
    rst_n = 1;
    chk("rst_cpu_rd", cpu_rd, 32'h0);
    chk("rst_ready", {31'b0, cpu_ready}, 32'h0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'h0);

    // Load miss with ack on the third memory cycle, then a hit
    mem_m[32'h40] = 32'hDEADBEEF;
    do_access(0, 32'h40, 0, 3, 0);
    chk("miss_rd_lit", cpu_rd, 32'hDEADBEEF);
    chk("miss_cnt_lit", 32'(miss_count), 32'd1);
    do_access(0, 32'h40, 0, 1, 0);
    chk("hit_rd_lit", cpu_rd, 32'hDEADBEEF);
    chk("hit_cnt_lit", 32'(hit_count), 32'd1);

    // LRU eviction within set 0
    do_reset();
    do_access(0, 32'h000, 0, 1, 0);
    do_access(0, 32'h100, 0, 2, 0);
    do_access(0, 32'h000, 0, 1, 0);
    do_access(0, 32'h200, 0, 1, 0);
    do_access(0, 32'h000, 0, 1, 0);
    do_access(0, 32'h100, 0, 1, 0);
    chk("lru_miss_lit", 32'(miss_count), 32'd4);
    chk("lru_hit_lit", 32'(hit_count), 32'd2);

    // Store hit updates the line; store miss writes memory only
    do_reset();
    do_access(0, 32'h40, 0, 1, 0);
    do_access(1, 32'h40, 32'h12345678, 2, 0);
    do_access(0, 32'h40, 0, 1, 0);
    chk("st_hit_rd_lit", cpu_rd, 32'h12345678);
    do_access(1, 32'h80, 32'hCAFEF00D, 1, 0);
    do_access(0, 32'h80, 0, 1, 0);
    chk("st_miss_rd_lit", cpu_rd, 32'hCAFEF00D);
    chk("st_miss_lit", 32'(miss_count), 32'd2);
    chk("st_hit_lit", 32'(hit_count), 32'd2);

    // Flush wins over a simultaneous request and empties the cache
    do_access(0, 32'h000, 0, 1, 0);
    flush_cycle(1, 32'h40);
    do_access(0, 32'h000, 0, 1, 0);
    do_access(0, 32'h40, 0, 1, 0);
    chk("flush_miss_lit", 32'(miss_count), 32'd5);
    chk("flush_hit_lit", 32'(hit_count), 32'd2);

    // Reset during a refill: mem_req drops at once, late ack ignored
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h60;
    exp_ready = 0; exp_mreq = 0;
    @(posedge clk); #1;
    exp_miss = sat_inc(exp_miss); exp_mreq = 1; exp_mwe = 0; exp_maddr = 32'h60;
    @(posedge clk); #2;
    rst_n = 0; #1;
    chk("rst_async_mem_req", {31'b0, mem_req}, 32'h0);
    cpu_req = 0; m_clear(); exp_hit = 0; exp_miss = 0; exp_mreq = 0;
    chk("rst_mid_hit_lit", 32'(hit_count), 32'd0);
    chk("rst_mid_miss_lit", 32'(miss_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1; mem_ack = 1; mem_rd = $urandom;
    @(posedge clk); #1;
    mem_ack = 0;
    do_access(0, 32'h60, 0, 1, 0);
    chk("rst_refetch_lit", 32'(miss_count), 32'd1);

    // Hit counter saturation
    repeat (17) do_access(0, 32'h60, 0, 1, 0);
    chk("hit_sat_lit", 32'(hit_count), 32'hF);

    // Random traffic over a few tags per set
    for (int n = 0; n < 400; n++) begin
      tag = 27'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) tag = tag | 27'h4000000;
      addr = {tag, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      case ($urandom_range(0, 99)) inside
        [0:1]:   do_reset();
        [2:4]:   flush_cycle($urandom_range(0, 1) == 1, addr);
        [5:9]:   idle($urandom_range(1, 2));
        [10:39]: do_access(1, addr, $urandom, $urandom_range(1, 4), $urandom_range(0, 9) == 0);
        default: do_access(0, addr, 0, $urandom_range(1, 4), $urandom_range(0, 9) == 0);
      endcase
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
